// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external memory port between instruction fetch
// and MEM-stage data access. Requests are served one at a time over a req/ack
// handshake that allows any memory latency. An optional timeout aborts hung
// accesses. Data requests are granted before fetch requests.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  // fetch requester
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_instr,
  // data requester
  input  logic        d_req,
  input  logic        d_wr,
  input  logic        d_sb,
  input  logic        d_sh,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  // external memory port
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  // pipeline control
  output logic        stall,
  output logic        timeout_err
);

  // A zero TIMEOUT disables the timeout; keep a 1-bit counter so widths stay legal.
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned TLAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  localparam logic [31:0] ERR_DATA = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   tcnt, tcnt_d;
  logic               mem_req_d, mem_wr_d;
  logic [1:0]         mem_size_d;
  logic [31:0]        mem_addr_d, mem_wdata_d;
  logic               if_done_d, d_done_d;
  logic [31:0]        if_instr_d, d_rdata_d;
  logic               timeout_err_d;
  logic               acked;
  logic               expired;

  // Completion and timeout qualifiers for the current bus cycle.
  always_comb begin
    acked   = mem_req & mem_ack;
    expired = 1'b0;
    if (TIMEOUT > 0) begin
      expired = mem_req & ~mem_ack & (tcnt == CNT_W'(TLAST));
    end
  end

  // Next-state and next-output logic; every output register is computed here.
  always_comb begin
    state_d       = state;
    tcnt_d        = tcnt;
    mem_req_d     = mem_req;
    mem_wr_d      = mem_wr;
    mem_size_d    = mem_size;
    mem_addr_d    = mem_addr;
    mem_wdata_d   = mem_wdata;
    if_done_d     = 1'b0;
    d_done_d      = 1'b0;
    if_instr_d    = if_instr;
    d_rdata_d     = d_rdata;
    timeout_err_d = timeout_err;

    unique case (state)
      IDLE: begin
        if (d_req) begin
          state_d     = DATA;
          tcnt_d      = '0;
          mem_req_d   = 1'b1;
          mem_wr_d    = d_wr;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          if (d_sb) begin
            mem_size_d = SIZE_BYTE;
          end else if (d_sh) begin
            mem_size_d = SIZE_HALF;
          end else begin
            mem_size_d = SIZE_WORD;
          end
        end else if (if_req) begin
          state_d    = FETCH;
          tcnt_d     = '0;
          mem_req_d  = 1'b1;
          mem_wr_d   = 1'b0;
          mem_size_d = SIZE_WORD;
          mem_addr_d = if_addr;
        end
      end

      DATA, FETCH: begin
        if (acked) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          if (state == FETCH) begin
            if_done_d  = 1'b1;
            if_instr_d = mem_rdata;
          end else begin
            d_done_d = 1'b1;
            if (!mem_wr) begin
              d_rdata_d = mem_rdata;
            end
          end
        end else if (expired) begin
          state_d       = RESP;
          mem_req_d     = 1'b0;
          timeout_err_d = 1'b1;
          if (state == FETCH) begin
            if_done_d  = 1'b1;
            if_instr_d = ERR_DATA;
          end else begin
            d_done_d = 1'b1;
            if (!mem_wr) begin
              d_rdata_d = ERR_DATA;
            end
          end
        end else if (TIMEOUT > 0) begin
          tcnt_d = tcnt + CNT_W'(1);
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      tcnt        <= '0;
      mem_req     <= 1'b0;
      mem_wr      <= 1'b0;
      mem_size    <= 2'b00;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      if_done     <= 1'b0;
      d_done      <= 1'b0;
      if_instr    <= '0;
      d_rdata     <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      tcnt        <= tcnt_d;
      mem_req     <= mem_req_d;
      mem_wr      <= mem_wr_d;
      mem_size    <= mem_size_d;
      mem_addr    <= mem_addr_d;
      mem_wdata   <= mem_wdata_d;
      if_done     <= if_done_d;
      d_done      <= d_done_d;
      if_instr    <= if_instr_d;
      d_rdata     <= d_rdata_d;
      timeout_err <= timeout_err_d;
    end
  end

  // Pipeline freeze; drops in the done cycle so the pipeline advances once.
  assign stall = (if_req & ~if_done) | (d_req & ~d_done);

endmodule
